mem_bus_responder: RTL and testbench

Data-side responder for the pipelined MIPS CPU's MEM stage. It answers every load/store the CPU issues: word-addressed data RAM plus memory-mapped timer, LED, 7-segment and systick registers. It also raises a level timer interrupt back to the core. Reads are combinational, so load data is valid within the MEM cycle; all state updates occur on the clock edge.

---
 rtl/mmio_pkg.sv | 46 ++++
 rtl/mmio_timer.sv | 63 ++++++
 rtl/mem_bus_responder.sv | 113 +++++++++++
 tb/tb_mem_bus_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Summary  : Peripheral window base, register offsets, TCON bits and decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h4000_0000;
    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_W  = 3;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_LED,
        REG_DIGITS,
        REG_SYSTICK
    } mmio_reg_e;

    // Only exact word addresses hit; any other offset is a miss.
    function automatic mmio_reg_e decodeMmio(input logic [31:0] addr, input logic [31:0] base);
        mmio_reg_e sel;
        sel = REG_NONE;
        if (addr == base + OFF_TH)           sel = REG_TH;
        else if (addr == base + OFF_TL)      sel = REG_TL;
        else if (addr == base + OFF_TCON)    sel = REG_TCON;
        else if (addr == base + OFF_LED)     sel = REG_LED;
        else if (addr == base + OFF_DIGITS)  sel = REG_DIGITS;
        else if (addr == base + OFF_SYSTICK) sel = REG_SYSTICK;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Summary  : Auto-reload timer (TH/TL/TCON) with sticky status and level irq.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wrTh,
    input  logic              i_wrTl,
    input  logic              i_wrTcon,
    input  logic [31:0]       i_wrData,
    output logic [31:0]       o_th,
    output logic [31:0]       o_tl,
    output logic [TCON_W-1:0] o_tcon,
    output logic              o_irq
);

    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [TCON_W-1:0] r_tcon;
    logic              w_wrap;

    assign w_wrap = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

    // A CPU write to TL suppresses both the reload and the status set;
    // a CPU write to TCON replaces the status but leaves TL counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (i_wrTh) begin
                r_th <= i_wrData;
            end

            if (i_wrTl) begin
                r_tl <= i_wrData;
            end else if (w_wrap) begin
                r_tl <= r_th;
            end else if (r_tcon[TCON_EN]) begin
                r_tl <= r_tl + 32'd1;
            end

            if (i_wrTcon) begin
                r_tcon <= i_wrData[TCON_W-1:0];
            end else if (w_wrap && r_tcon[TCON_IE] && !i_wrTl) begin
                r_tcon[TCON_ST] <= 1'b1;
            end
        end
    end

    assign o_th   = r_th;
    assign o_tl   = r_tl;
    assign o_tcon = r_tcon;
    assign o_irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Summary  : MEM-stage data RAM plus timer/LED/7-segment/systick registers.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = mmio_pkg::MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        LoadByte,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    import mmio_pkg::*;

    localparam int          c_IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] c_RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0]        r_ram [RAM_WORDS];
    logic [7:0]         r_leds;
    logic [11:0]        r_digits;
    logic [31:0]        r_sysTick;

    logic               w_ramHit;
    logic [c_IDX_W-1:0] w_ramIdx;
    mmio_reg_e          w_reg;
    logic               w_wrEn;
    logic [31:0]        w_th;
    logic [31:0]        w_tl;
    logic [TCON_W-1:0]  w_tcon;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;

    assign w_ramHit = (Address < c_RAM_BYTES);
    assign w_ramIdx = Address[c_IDX_W+1:2];
    assign w_reg    = decodeMmio(Address, MMIO_BASE);
    assign w_wrEn   = MemWrite && !reset;

    mmio_timer u_timer (
        .clk      (clk),
        .rst      (reset),
        .i_wrTh   (w_wrEn && (w_reg == REG_TH)),
        .i_wrTl   (w_wrEn && (w_reg == REG_TL)),
        .i_wrTcon (w_wrEn && (w_reg == REG_TCON)),
        .i_wrData (WriteData),
        .o_th     (w_th),
        .o_tl     (w_tl),
        .o_tcon   (w_tcon),
        .o_irq    (irq)
    );

    // RAM contents survive reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (w_wrEn && w_ramHit) begin
            r_ram[w_ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds    <= '0;
            r_digits  <= '0;
            r_sysTick <= '0;
        end else begin
            r_sysTick <= r_sysTick + 32'd1;
            if (w_wrEn && (w_reg == REG_LED)) begin
                r_leds <= WriteData[7:0];
            end
            if (w_wrEn && (w_reg == REG_DIGITS)) begin
                r_digits <= WriteData[11:0];
            end
        end
    end

    always_comb begin
        w_word = '0;
        if (w_ramHit) begin
            w_word = r_ram[w_ramIdx];
        end else begin
            case (w_reg)
                REG_TH:      w_word = w_th;
                REG_TL:      w_word = w_tl;
                REG_TCON:    w_word = 32'(w_tcon);
                REG_LED:     w_word = 32'(r_leds);
                REG_DIGITS:  w_word = 32'(r_digits);
                REG_SYSTICK: w_word = r_sysTick;
                default:     w_word = '0;
            endcase
        end

        w_byte = w_word[{Address[1:0], 3'b000} +: 8];

        ReadData = '0;
        if (MemRead) begin
            ReadData = LoadByte ? {{24{w_byte[7]}}, w_byte} : w_word;
        end
    end

    assign leds   = r_leds;
    assign digits = r_digits;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Summary  : Scoreboard bench for mem_bus_responder with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

    localparam int          RAM_WORDS = 256;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [31:0] BASE      = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        LoadByte;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    always #5 clk = ~clk;

    mem_bus_responder #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .LoadByte  (LoadByte),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .leds      (leds),
        .digits    (digits),
        .irq       (irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  leds;
        logic [11:0] digits;
        logic        irq;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state
    logic [31:0] mRam [RAM_WORDS];
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [7:0]  mLeds;
    logic [11:0] mDigits;

    function automatic logic [31:0] mWord(input logic [31:0] a);
        if (a < RAM_BYTES) return mRam[int'(a >> 2) % RAM_WORDS];
        if (a == BASE + 32'h00) return mTh;
        if (a == BASE + 32'h04) return mTl;
        if (a == BASE + 32'h08) return {29'd0, mTcon};
        if (a == BASE + 32'h0C) return {24'd0, mLeds};
        if (a == BASE + 32'h10) return {20'd0, mDigits};
        if (a == BASE + 32'h14) return mSys;
        return 32'd0;
    endfunction

    function automatic logic [31:0] mRead(input logic rd, input logic lb, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        if (!rd) return 32'd0;
        w = mWord(a);
        if (!lb) return w;
        b = 8'(w >> (8 * a[1:0]));
        return {{24{b[7]}}, b};
    endfunction

    task automatic mStep(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] nTl;
        logic [2:0]  nTcon;
        logic        wrap;
        if (rst) begin
            mTh = 0; mTl = 0; mTcon = 0; mLeds = 0; mDigits = 0; mSys = 0;
            return;
        end
        wrap  = mTcon[0] && (mTl == 32'hFFFF_FFFF);
        nTl   = mTcon[0] ? (wrap ? mTh : mTl + 32'd1) : mTl;
        nTcon = (wrap && mTcon[1]) ? (mTcon | 3'b100) : mTcon;
        mSys  = mSys + 32'd1;
        if (wr) begin
            if (a < RAM_BYTES) mRam[int'(a >> 2) % RAM_WORDS] = wd;
            else if (a == BASE + 32'h00) mTh = wd;
            else if (a == BASE + 32'h04) begin nTl = wd; nTcon = mTcon; end
            else if (a == BASE + 32'h08) nTcon = wd[2:0];
            else if (a == BASE + 32'h0C) mLeds = wd[7:0];
            else if (a == BASE + 32'h10) mDigits = wd[11:0];
        end
        mTl   = nTl;
        mTcon = nTcon;
    endtask

    task automatic doCycle(input logic rst, input logic rd, input logic wr, input logic lb,
                           input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        reset = rst; MemRead = rd; MemWrite = wr; LoadByte = lb; Address = a; WriteData = wd;
        e.rd     = mRead(rd, lb, a);
        e.leds   = mLeds;
        e.digits = mDigits;
        e.irq    = mTcon[1] & mTcon[2];
        expQ.push_back(e);
        mStep(rst, wr, a, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic wrw(input logic [31:0] a, input logic [31:0] d); doCycle(0, 0, 1, 0, a, d); endtask
    task automatic rdw(input logic [31:0] a); doCycle(0, 1, 0, 0, a, 0); endtask
    task automatic rdb(input logic [31:0] a); doCycle(0, 1, 0, 1, a, 0); endtask
    task automatic idle(); doCycle(0, 0, 0, 0, 0, 0); endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("ReadData", ReadData, e.rd);
                chk("leds", 32'(leds), 32'(e.leds));
                chk("digits", 32'(digits), 32'(e.digits));
                chk("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        int          kind;
        reset = 1; MemRead = 0; MemWrite = 0; LoadByte = 0; Address = 0; WriteData = 0;
        repeat (2) @(posedge clk);
        #1;
        mStep(1, 0, 0, 0);

        rdw(BASE + 32'h14);
        rdw(BASE + 32'h14);
        for (int i = 0; i < RAM_WORDS; i++) wrw(32'(i * 4), $urandom);

        // Byte lanes and sign extension
        wrw(32'h10, 32'h8765_43A1);
        rdw(32'h10); rdb(32'h10); rdb(32'h13); rdb(32'h11); rdb(32'h12);

        // Reload and sticky status
        wrw(BASE + 32'h00, 32'hFFFF_FFF0);
        wrw(BASE + 32'h04, 32'hFFFF_FFFE);
        wrw(BASE + 32'h08, 32'h3);
        rdw(BASE + 32'h04); rdw(BASE + 32'h04); rdw(BASE + 32'h04); rdw(BASE + 32'h08);
        wrw(BASE + 32'h08, 32'h3);
        rdw(BASE + 32'h08); rdw(BASE + 32'h04);

        // TCON write in the wrap cycle
        wrw(BASE + 32'h08, 32'h0);
        wrw(BASE + 32'h04, 32'hFFFF_FFFE);
        wrw(BASE + 32'h08, 32'h3);
        rdw(BASE + 32'h04);
        doCycle(0, 1, 1, 0, BASE + 32'h08, 32'h1);
        rdw(BASE + 32'h08); rdw(BASE + 32'h04);

        // TL write in the wrap cycle
        wrw(BASE + 32'h08, 32'h0);
        wrw(BASE + 32'h04, 32'hFFFF_FFFE);
        wrw(BASE + 32'h08, 32'h3);
        idle();
        wrw(BASE + 32'h04, 32'h5);
        rdw(BASE + 32'h08); rdw(BASE + 32'h04);

        // Narrow registers, miss, read-only systick
        wrw(BASE + 32'h0C, 32'h1A5);
        wrw(BASE + 32'h10, 32'hFFFF);
        rdw(BASE + 32'h0C); rdw(BASE + 32'h10); rdw(BASE + 32'h18);
        wrw(BASE + 32'h14, 32'h1234_5678);
        rdw(BASE + 32'h14);

        // Reset mid-run with irq high; a store in the reset cycle is dropped
        wrw(BASE + 32'h04, 32'hFFFF_FFFE);
        wrw(BASE + 32'h08, 32'h3);
        idle(); idle(); idle();
        doCycle(1, 0, 1, 0, 32'h10, 32'hDEAD_BEEF);
        rdw(BASE + 32'h14); rdw(BASE + 32'h14); rdw(32'h10); rdw(BASE + 32'h08);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4)      a = 32'($urandom_range(0, 1023));
            else if (kind <= 7) a = BASE + 32'(4 * $urandom_range(0, 5));
            else if (kind == 8) a = BASE + 32'($urandom_range(0, 31));
            else                a = $urandom;
            d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            doCycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
        end

        MemRead = 0; MemWrite = 0; reset = 0;
        for (int t = 0; t < 10 && expQ.size() > 0; t++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
